// File: rtl/step_pkg.sv
// Shared types and default constants for the step pushbutton debouncer.
package step_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        ARM_PRESS,
        PRESSED,
        ARM_RELEASE
    } step_state_t;

    // 20 ms of stable samples at 50 MHz.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
    localparam int SYNC_STAGES_DEFAULT     = 2;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for asynchronous switch inputs, with a selectable preset value.
module sync_chain #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= RESET_VAL;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/step_debouncer.sv
// Debounces the active-low step pushbutton into the clean manual step clock CLKb,
// with registered press/release strobes and a wrapping press count.
module step_debouncer
    import step_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       KEYb,
    output logic       CLKb,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic [7:0] press_count
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_key_s;
    step_state_t      r_state,   w_state_nxt;
    logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
    logic             r_clkb,    w_clkb_nxt;
    logic             r_press,   w_press_nxt;
    logic             r_release, w_release_nxt;
    logic [7:0]       r_count,   w_count_nxt;

    // Presets to released so a reset never fabricates a press.
    sync_chain #(
        .WIDTH     (1),
        .DEPTH     (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_key_sync (
        .i_clk (CLOCK_50),
        .i_rst (reset),
        .i_d   (KEYb),
        .o_q   (w_key_s)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state   <= RELEASED;
            r_cnt     <= '0;
            r_clkb    <= 1'b1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_count   <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_clkb    <= w_clkb_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_count   <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_clkb_nxt    = r_clkb;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_count_nxt   = r_count;

        case (r_state)
            RELEASED: begin
                if (!w_key_s) begin
                    w_state_nxt = ARM_PRESS;
                    w_cnt_nxt   = '0;
                end
            end
            ARM_PRESS: begin
                // Any bounce back to released discards the partial count.
                if (w_key_s) begin
                    w_state_nxt = RELEASED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                    w_clkb_nxt  = 1'b0;
                    w_press_nxt = 1'b1;
                    w_count_nxt = r_count + 8'd1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (w_key_s) begin
                    w_state_nxt = ARM_RELEASE;
                    w_cnt_nxt   = '0;
                end
            end
            ARM_RELEASE: begin
                if (!w_key_s) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt   = RELEASED;
                    w_cnt_nxt     = '0;
                    w_clkb_nxt    = 1'b1;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = RELEASED;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign CLKb          = r_clkb;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign press_count   = r_count;

endmodule

// File: tb/tb_step_debouncer.sv
// Bench for step_debouncer: directed scenarios plus random bouncing, checked against a
// run-length reference model built from the sampled button history.
module tb_step_debouncer;

    localparam int SYNC = 2;
    localparam int DC   = 8;
    localparam int HIST = 1024;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b0;
    logic       KEYb     = 1'b1;
    logic       CLKb;
    logic       press_pulse;
    logic       release_pulse;
    logic [7:0] press_count;

    int n_checks = 0;
    int n_err    = 0;

    step_debouncer #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .KEYb          (KEYb),
        .CLKb          (CLKb),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .press_count   (press_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Reference: every edge's KEYb sample is logged; the debounced level flips once
    // DC+1 consecutive samples (seen SYNC edges late) disagree with it.
    int unsigned m_edge;
    bit          m_samp [HIST];
    bit          m_level;
    int          m_run;
    bit          m_pp;
    bit          m_rp;
    logic [7:0]  m_cnt;

    function automatic bit seen_key();
        int unsigned n;
        n = m_edge + 1;
        if (n > SYNC) return m_samp[(n - SYNC) % HIST];
        return 1'b1;
    endfunction

    always @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            m_edge  <= 0;
            m_level <= 1'b1;
            m_run   <= 0;
            m_pp    <= 1'b0;
            m_rp    <= 1'b0;
            m_cnt   <= 8'd0;
        end else begin
            m_edge                      <= m_edge + 1;
            m_samp[(m_edge + 1) % HIST] <= KEYb;
            m_pp                        <= 1'b0;
            m_rp                        <= 1'b0;
            if (seen_key() != m_level) begin
                if (m_run == DC) begin
                    m_level <= ~m_level;
                    m_run   <= 0;
                    if (m_level) begin
                        m_pp  <= 1'b1;
                        m_cnt <= m_cnt + 8'd1;
                    end else begin
                        m_rp <= 1'b1;
                    end
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                m_run <= 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("model_clkb",    8'(CLKb),          8'(m_level));
        chk("model_press",   8'(press_pulse),   8'(m_pp));
        chk("model_release", 8'(release_pulse), 8'(m_rp));
        chk("model_count",   press_count,       m_cnt);
    endtask

    int  remaining;
    int  len;
    bit  v;

    initial begin
        // Reset values
        #2 reset = 1'b1;
        #1;
        chk("rst_clkb",    8'(CLKb),          8'd1);
        chk("rst_press",   8'(press_pulse),   8'd0);
        chk("rst_release", 8'(release_pulse), 8'd0);
        chk("rst_count",   press_count,       8'd0);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (3) step();

        // Clean press: falls on edge 11
        KEYb = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            step();
            chk("press_clkb",  8'(CLKb),        (e >= 11) ? 8'd0 : 8'd1);
            chk("press_pulse", 8'(press_pulse), (e == 11) ? 8'd1 : 8'd0);
        end
        chk("press_count1", press_count, 8'd1);

        // Clean release: rises on edge 11
        KEYb = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            step();
            chk("release_clkb",  8'(CLKb),          (e >= 11) ? 8'd1 : 8'd0);
            chk("release_pulse", 8'(release_pulse), (e == 11) ? 8'd1 : 8'd0);
        end
        chk("release_count", press_count, 8'd1);

        // Single-cycle glitch while released
        KEYb = 1'b0;
        step();
        KEYb = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            step();
            chk("glitch_clkb",  8'(CLKb),        8'd1);
            chk("glitch_press", 8'(press_pulse), 8'd0);
            chk("glitch_count", press_count,     8'd1);
        end

        // Bounce burst: 5 low, 1 high, then held low
        KEYb = 1'b0;
        repeat (5) begin
            step();
            chk("bounce_burst_clkb", 8'(CLKb), 8'd1);
        end
        KEYb = 1'b1;
        step();
        chk("bounce_burst_clkb", 8'(CLKb), 8'd1);
        KEYb = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            step();
            chk("bounce_clkb", 8'(CLKb), (e >= 11) ? 8'd0 : 8'd1);
        end
        chk("bounce_count", press_count, 8'd2);
        KEYb = 1'b1;
        repeat (14) step();
        chk("bounce_released", 8'(CLKb), 8'd1);

        // Random bouncing runs of 1..14 samples
        remaining = 2000;
        v = 1'b0;
        while (remaining > 0) begin
            len = int'($urandom_range(1, 14));
            KEYb = v;
            repeat (len) step();
            remaining -= len;
            v = ~v;
        end
        KEYb = 1'b1;
        repeat (20) step();
        chk("random_settled", 8'(CLKb), 8'd1);

        // Wrap: 256 clean pairs from a fresh reset
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        for (int p = 0; p < 256; p++) begin
            KEYb = 1'b0;
            repeat (12) step();
            KEYb = 1'b1;
            repeat (12) step();
            if (p == 254) chk("wrap_count255", press_count, 8'd255);
        end
        chk("wrap_count0", press_count, 8'd0);
        chk("wrap_clkb",   8'(CLKb),    8'd1);

        // Asynchronous reset while pressed, button held through deassertion
        KEYb = 1'b0;
        repeat (12) step();
        chk("pre_reset_clkb",  8'(CLKb),    8'd0);
        chk("pre_reset_count", press_count, 8'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_clkb",  8'(CLKb),        8'd1);
        chk("async_rst_count", press_count,     8'd0);
        chk("async_rst_press", 8'(press_pulse), 8'd0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            step();
            chk("held_clkb", 8'(CLKb), (e >= 11) ? 8'd0 : 8'd1);
        end
        chk("held_count", press_count, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
